slow2fast_handshake: RTL and testbench

Clock-domain-crossing receiver that delivers single-cycle events with data from a slow clock domain into the fast domain. It is the counterpart of the fast-to-slow pulse stretcher. Each source event is captured into a holding register and signalled by a toggle request. The fast domain synchronises the toggle, emits exactly one `clk_fast` pulse with stable data, and returns a toggle acknowledge so the source knows when it may send again. Events offered while a transfer is in flight are dropped and counted.

---
 rtl/slow2fast_handshake_if.sv | 23 ++
 rtl/slow2fast_handshake.sv | 88 ++++++++
 tb/tb_slow2fast_handshake.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slow2fast_handshake_if.sv
// Handshake and payload bundle between the slow-domain source and the fast-domain sink.
`timescale 1ns/1ps
interface slow2fast_handshake_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DROP_W = 8
);
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic              src_busy;
   logic [DROP_W-1:0] src_drop_cnt;
   logic              dst_valid;
   logic [DATA_W-1:0] dst_data;

   modport master (
      output src_valid, src_data,
      input  src_busy, src_drop_cnt, dst_valid, dst_data
   );

   modport slave (
      input  src_valid, src_data,
      output src_busy, src_drop_cnt, dst_valid, dst_data
   );
endinterface

// File: rtl/slow2fast_handshake.sv
// Toggle-handshake CDC: slow-domain events with payload delivered as single fast-domain pulses.
`timescale 1ns/1ps
module slow2fast_handshake #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DROP_W      = 8
) (
   input  logic                 clk_fast,
   input  logic                 clk_slow,
   input  logic                 sys_rst_n,
   slow2fast_handshake_if.slave bus
);

   // slow domain state
   logic                   req_tgl;
   logic [DATA_W-1:0]      hold_q;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic [DROP_W-1:0]      drop_cnt_q;
   logic                   src_busy_c;
   logic                   accept_c;
   logic                   drop_c;

   // fast domain state
   logic [SYNC_STAGES-1:0] req_sync;
   logic                   req_prev;
   logic                   ack_tgl;
   logic                   dst_valid_q;
   logic [DATA_W-1:0]      dst_data_q;
   logic                   req_edge_c;

   // Busy is the mismatch between our request toggle and the returned acknowledge.
   always_comb begin
      src_busy_c = req_tgl ^ ack_sync[SYNC_STAGES-1];
      accept_c   = bus.src_valid & ~src_busy_c;
      drop_c     = bus.src_valid & src_busy_c & (drop_cnt_q != {DROP_W{1'b1}});
   end

   // Source capture, request toggle and acknowledge synchroniser.
   always_ff @(posedge clk_slow or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         req_tgl  <= 1'b0;
         hold_q   <= '0;
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
         if (accept_c) begin
            hold_q  <= bus.src_data;
            req_tgl <= ~req_tgl;
         end
      end
   end

   // Saturating count of events offered while a transfer is in flight.
   always_ff @(posedge clk_slow or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         drop_cnt_q <= '0;
      end else if (drop_c) begin
         drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
   end

   assign req_edge_c = req_sync[SYNC_STAGES-1] ^ req_prev;

   // Request synchroniser and edge detect; hold_q is quiescent while the toggle is in flight.
   always_ff @(posedge clk_fast or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         req_sync    <= '0;
         req_prev    <= 1'b0;
         ack_tgl     <= 1'b0;
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         req_sync    <= {req_sync[SYNC_STAGES-2:0], req_tgl};
         req_prev    <= req_sync[SYNC_STAGES-1];
         ack_tgl     <= req_sync[SYNC_STAGES-1];
         dst_valid_q <= req_edge_c;
         if (req_edge_c) begin
            dst_data_q <= hold_q;
         end
      end
   end

   assign bus.src_busy     = src_busy_c;
   assign bus.src_drop_cnt = drop_cnt_q;
   assign bus.dst_valid    = dst_valid_q;
   assign bus.dst_data     = dst_data_q;

endmodule

// File: tb/tb_slow2fast_handshake.sv
// Self-checking bench: directed vectors, saturation, reset abort and ratio sweeps with a scoreboard.
`timescale 1ns/1ps
module tb_slow2fast_handshake;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DROP_W = 8;

   logic clk_fast  = 1'b0;
   logic clk_slow  = 1'b0;
   logic sys_rst_n = 1'b1;
   logic fast_en   = 1'b1;
   real  fast_half = 5.0;
   real  slow_half = 50.0;

   slow2fast_handshake_if #(.DATA_W(DATA_W), .DROP_W(DROP_W)) bus ();

   slow2fast_handshake #(
      .DATA_W(DATA_W), .SYNC_STAGES(2), .DROP_W(DROP_W)
   ) dut (
      .clk_fast (clk_fast),
      .clk_slow (clk_slow),
      .sys_rst_n(sys_rst_n),
      .bus      (bus.slave)
   );

   always begin
      #(fast_half);
      if (fast_en) clk_fast = ~clk_fast;
   end

   always begin
      #(slow_half);
      clk_slow = ~clk_slow;
   end

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_data;
      logic [7:0] exp_drop;
   } vec_t;

   vec_t            vecs [4];
   logic [7:0]      exp_q [$];
   int              n_cmp = 0;
   int              n_err = 0;
   int              n_dst = 0;
   int              n_acc = 0;
   int              n_vld = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Scoreboard: every fast-domain pulse must match the oldest accepted event.
   always @(negedge clk_fast) begin : monitor
      logic [7:0] e;
      if (bus.dst_valid === 1'b1) begin
         n_dst++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_dst_valid: got data %0h expected no pulse at %0t", bus.dst_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(bus.dst_data), 32'(e));
         end
      end
   end

   task automatic slow_step(input logic v, input logic [7:0] d);
      @(negedge clk_slow);
      bus.src_valid = v;
      bus.src_data  = d;
      if (v) n_vld++;
      if (v && !bus.src_busy) begin
         exp_q.push_back(d);
         n_acc++;
      end
      @(posedge clk_slow);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      sys_rst_n     = 1'b0;
      bus.src_valid = 1'b0;
      exp_q.delete();
      repeat (cycles) @(negedge clk_slow);
      exp_q.delete();
      sys_rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (bus.src_busy && k < 50) begin
         @(posedge clk_slow);
         #1;
         k++;
      end
      if (bus.src_busy) timeout_fail("wait_idle");
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || bus.src_busy) && k < budget) begin
         @(posedge clk_slow);
         #1;
         k++;
      end
      if (exp_q.size() != 0 || bus.src_busy) timeout_fail("drain");
   endtask

   // One isolated transfer with forward latency, pulse width and busy duration checks.
   task automatic single_xfer(input logic [7:0] din, input logic [7:0] exp_data, input logic [7:0] exp_drop);
      int edges = 0;
      int bcyc  = 0;
      wait_idle();
      @(negedge clk_slow);
      bus.src_valid = 1'b1;
      bus.src_data  = din;
      exp_q.push_back(din);
      @(posedge clk_slow);
      #1;
      check("busy_on_accept", 32'(bus.src_busy), 32'd1);
      fork
         begin
            @(negedge clk_slow);
            bus.src_valid = 1'b0;
         end
      join_none
      while (bus.dst_valid !== 1'b1 && edges < 20) begin
         @(negedge clk_fast);
         edges++;
      end
      if (bus.dst_valid !== 1'b1) timeout_fail("dst_valid_wait");
      check("fwd_latency_3_or_4", 32'(edges >= 3 && edges <= 4), 32'd1);
      check("dst_data", 32'(bus.dst_data), 32'(exp_data));
      @(negedge clk_fast);
      check("pulse_width", 32'(bus.dst_valid), 32'd0);
      check("dst_data_held", 32'(bus.dst_data), 32'(exp_data));
      while (bus.src_busy && bcyc < 10) begin
         @(posedge clk_slow);
         #1;
         bcyc++;
      end
      check("busy_clears_within_4", 32'(bcyc <= 4 && !bus.src_busy), 32'd1);
      check("drop_cnt_single", 32'(bus.src_drop_cnt), 32'(exp_drop));
   endtask

   task automatic ratio_phase(input real fh, input real sh, input string tag);
      int d0;
      int a0;
      int v0;
      int delivered;
      int drops;
      sys_rst_n     = 1'b0;
      bus.src_valid = 1'b0;
      fast_half     = fh;
      slow_half     = sh;
      do_reset(4);
      d0 = n_dst;
      a0 = n_acc;
      v0 = n_vld;
      for (int i = 0; i < 1000; i++) begin
         slow_step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      @(negedge clk_slow);
      bus.src_valid = 1'b0;
      drain(3000);
      delivered = n_dst - d0;
      drops     = (n_vld - v0) - delivered;
      if (drops > 255) drops = 255;
      check({tag, "_delivered_eq_accepted"}, 32'(delivered), 32'(n_acc - a0));
      check({tag, "_some_delivered"}, 32'(delivered > 0), 32'd1);
      check({tag, "_drop_cnt"}, 32'(bus.src_drop_cnt), 32'(drops));
   endtask

   initial begin : main
      int d0;
      int delivered;

      vecs[0] = '{8'hA5, 8'hA5, 8'h00};
      vecs[1] = '{8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00};
      vecs[3] = '{8'h5A, 8'h5A, 8'h00};

      bus.src_valid = 1'b0;
      bus.src_data  = '0;

      // reset state
      #1;
      sys_rst_n = 1'b0;
      repeat (5) @(negedge clk_slow);
      check("rst_dst_valid", 32'(bus.dst_valid), 32'd0);
      check("rst_dst_data", 32'(bus.dst_data), 32'd0);
      check("rst_src_busy", 32'(bus.src_busy), 32'd0);
      check("rst_drop_cnt", 32'(bus.src_drop_cnt), 32'd0);
      sys_rst_n = 1'b1;
      repeat (20) @(negedge clk_fast);
      check("no_pulse_after_reset", 32'(n_dst), 32'd0);

      // directed single transfers
      for (int i = 0; i < 4; i++) begin
         single_xfer(vecs[i].din, vecs[i].exp_data, vecs[i].exp_drop);
      end

      // continuous stream, valid held high
      d0 = n_dst;
      for (int i = 0; i < 40; i++) begin
         slow_step(1'b1, 8'(i + 1));
      end
      @(negedge clk_slow);
      bus.src_valid = 1'b0;
      drain(200);
      delivered = n_dst - d0;
      check("stream_drop_cnt", 32'(bus.src_drop_cnt), 32'(40 - delivered));
      check("stream_some_accepts", 32'(delivered > 1 && delivered < 40), 32'd1);

      // drop saturation with the fast clock stopped
      do_reset(3);
      fast_en = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         slow_step(1'b1, 8'(i));
         if (i == 255) check("drop_cnt_254", 32'(bus.src_drop_cnt), 32'd254);
         if (i == 256) check("drop_cnt_255", 32'(bus.src_drop_cnt), 32'd255);
         if (i == 300) begin
            check("drop_cnt_stays_255", 32'(bus.src_drop_cnt), 32'd255);
            check("busy_stays_high", 32'(bus.src_busy), 32'd1);
         end
      end
      @(negedge clk_slow);
      bus.src_valid = 1'b0;
      do_reset(3);
      fast_en = 1'b1;
      repeat (5) @(negedge clk_slow);
      check("sat_reset_drop_cnt", 32'(bus.src_drop_cnt), 32'd0);

      // reset one fast cycle after the request toggles
      wait_idle();
      @(negedge clk_slow);
      bus.src_valid = 1'b1;
      bus.src_data  = 8'h77;
      @(posedge clk_slow);
      fork
         begin
            @(negedge clk_slow);
            bus.src_valid = 1'b0;
         end
      join_none
      @(posedge clk_fast);
      #1;
      sys_rst_n = 1'b0;
      d0 = n_dst;
      repeat (3) @(negedge clk_slow);
      bus.src_valid = 1'b0;
      sys_rst_n = 1'b1;
      repeat (20) @(negedge clk_fast);
      check("no_pulse_for_aborted", 32'(n_dst - d0), 32'd0);
      check("abort_busy_clear", 32'(bus.src_busy), 32'd0);
      single_xfer(8'h3C, 8'h3C, 8'h00);

      // ratio independence
      ratio_phase(5.0, 5.15, "ratio_near");
      ratio_phase(50.0, 5.0, "ratio_fast_slower");

      check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

endmodule
